prio_pkt_drain: RTL

Downstream consumer for the bank of per-priority packet FIFOs. It selects the highest-priority FIFO that has data and drains one complete packet (sop through eop) from it, one word per cycle. Each accepted word is written into the SRAM at a linearly incrementing, wrapping address. After the eop word it emits a descriptor (priority, start address, length) to the SRAM queue manager.

---
 rtl/prio_pkt_drain.sv | 137 +++++++++++++
 1 files changed

// File: rtl/prio_pkt_drain.sv
// Strict-priority packet drain: pops one whole packet from the highest-priority ready FIFO into
// SRAM at a wrapping write pointer, then hands a descriptor to the queue manager.
module prio_pkt_drain #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_PRI = 8,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PRI-1:0]        fifo_ready_i,
  input  logic [NUM_PRI-1:0]        fifo_sop_i,
  input  logic [NUM_PRI-1:0]        fifo_eop_i,
  input  logic [NUM_PRI-1:0]        fifo_vld_i,
  input  logic [NUM_PRI*DATA_W-1:0] fifo_data_i,
  output logic [NUM_PRI-1:0]        fifo_next_o,
  input  logic                      sram_wr_rdy_i,
  output logic                      sram_we_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  output logic [DATA_W-1:0]         sram_wdata_o,
  output logic                      desc_vld_o,
  input  logic                      desc_rdy_i,
  output logic [2:0]                desc_pri_o,
  output logic [ADDR_W-1:0]         desc_addr_o,
  output logic [ADDR_W:0]           desc_len_o,
  output logic                      desc_err_o,
  output logic [7:0]                drop_cnt_o
);

  typedef enum logic [1:0] {StIdle, StXfer, StDesc} state_e;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;
  logic [7:0]        drop_q, drop_d;

  logic [2:0]        pick;
  logic              head_sop, head_eop, head_vld, head_rdy;
  logic [DATA_W-1:0] head_data;
  logic              pop, discard, wr, in_desc;
  logic [ADDR_W:0]   len_inc;

  // Lowest ready index wins.
  always_comb begin
    pick = '0;
    for (int i = int'(NUM_PRI) - 1; i >= 0; i--) begin
      if (fifo_ready_i[i]) pick = 3'(i);
    end
  end

  always_comb begin
    head_rdy  = fifo_ready_i[grant_q];
    head_sop  = fifo_sop_i[grant_q];
    head_eop  = fifo_eop_i[grant_q];
    head_vld  = fifo_vld_i[grant_q];
    head_data = fifo_data_i[32'(grant_q) * DATA_W +: DATA_W];
    len_inc   = len_q + 1'b1;
    pop       = !rst && (state_q == StXfer) && head_rdy && sram_wr_rdy_i;
    // Words outside a sop-started packet, or flagged invalid, are popped and thrown away.
    discard   = !head_vld || (!head_sop && (len_q == '0));
    wr        = pop && !discard;
    in_desc   = !rst && (state_q == StDesc);
  end

  always_comb begin
    fifo_next_o = '0;
    if (pop) fifo_next_o[grant_q] = 1'b1;
    sram_we_o    = wr;
    sram_addr_o  = wr ? wptr_q : '0;
    sram_wdata_o = wr ? head_data : '0;
    desc_vld_o   = in_desc;
    desc_pri_o   = in_desc ? grant_q : '0;
    desc_addr_o  = in_desc ? start_q : '0;
    desc_len_o   = in_desc ? len_q : '0;
    desc_err_o   = in_desc ? err_q : 1'b0;
    drop_cnt_o   = drop_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wptr_d  = wptr_q;
    start_d = start_q;
    len_d   = len_q;
    err_d   = err_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (|fifo_ready_i) begin
          grant_d = pick;
          start_d = wptr_q;
          len_d   = '0;
          err_d   = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (pop && discard) begin
          if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
        end else if (wr) begin
          wptr_d = wptr_q + 1'b1;
          len_d  = len_inc;
          // A full-size packet without eop is truncated here; its tail drops as sop-less.
          err_d  = err_q | (head_sop && (len_q != '0)) | (len_inc[ADDR_W] && !head_eop);
          if (head_eop || len_inc[ADDR_W]) state_d = StDesc;
        end
      end
      StDesc: begin
        if (desc_rdy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      wptr_q  <= '0;
      start_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wptr_q  <= wptr_d;
      start_q <= start_d;
      len_q   <= len_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

endmodule
